// File: rtl/score_counter.sv
// Push-button scoreboard front end: synchronizes, debounces and edge-detects
// inc/dec/clear buttons and keeps a saturating two-digit BCD score (00..99).
module score_counter #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_btn_i,
  input  logic       dec_btn_i,
  input  logic       clr_btn_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       change_o
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = inc, bit 1 = dec, bit 2 = clr throughout.
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [2:0]    stable_q;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];

  assign raw   = {clr_btn_i, dec_btn_i, inc_btn_i};
  assign press = stable & ~stable_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  // NOTE: the debounce counters are reset too, so a reset mid-debounce drops
  // any partial count and a still-held button restarts from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic inc;
  logic dec;
  logic clr;
  logic [3:0] tens_n;
  logic [3:0] ones_n;

  assign inc = press[0];
  assign dec = press[1];
  assign clr = press[2];

  // NOTE: defaults first so every path assigns both digits and no latch forms.
  always_comb begin
    tens_n = tens_o;
    ones_n = ones_o;
    if (clr) begin
      tens_n = '0;
      ones_n = '0;
    end else if (inc && !dec) begin
      if (ones_o != 4'd9) begin
        ones_n = ones_o + 4'd1;
      end else if (tens_o != 4'd9) begin
        ones_n = '0;
        tens_n = tens_o + 4'd1;
      end
    end else if (dec && !inc) begin
      if (ones_o != 4'd0) begin
        ones_n = ones_o - 4'd1;
      end else if (tens_o != 4'd0) begin
        ones_n = 4'd9;
        tens_n = tens_o - 4'd1;
      end
    end
  end

  // change_o flags a real value change only, so saturation and no-ops stay quiet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_o   <= '0;
      ones_o   <= '0;
      change_o <= 1'b0;
    end else begin
      tens_o   <= tens_n;
      ones_o   <= ones_n;
      change_o <= ({tens_n, ones_n} != {tens_o, ones_o});
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter: an integer score model queues expected
// BCD values per press; a monitor pops one on every change_o pulse.
module tb_score_counter;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       change;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_score = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  score_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_btn_i (inc),
    .dec_btn_i (dec),
    .clr_btn_i (clr),
    .tens_o    (tens),
    .ones_o    (ones),
    .change_o  (change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Reference model: plain integer arithmetic on the score.
  function automatic void apply(input bit i, input bit d, input bit c);
    int nxt;
    nxt = model_score;
    if (c)            nxt = 0;
    else if (i && !d) nxt = (model_score >= 99) ? 99 : model_score + 1;
    else if (d && !i) nxt = (model_score <= 0) ? 0 : model_score - 1;
    if (nxt != model_score) exp_q.push_back(to_bcd(nxt));
    model_score = nxt;
  endfunction

  task automatic press(input bit i, input bit d, input bit c, input int hold, input int gap);
    @(negedge clk);
    inc = i; dec = d; clr = c;
    apply(i, d, c);
    repeat (hold) @(negedge clk);
    inc = 0; dec = 0; clr = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    inc = 1;
    repeat (n) @(negedge clk);
    inc = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1, 0, 0, DC + 2, DC + 6);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("tens_range", tens <= 4'd9, 1);
      check("ones_range", ones <= 4'd9, 1);
      if (change) begin
        if (exp_q.size() == 0) begin
          check("spurious_change", change, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("score_on_change", {tens, ones}, mon_exp);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    repeat (3) @(negedge clk);
    check("reset_score", {tens, ones}, 8'h00);
    check("reset_change", change, 0);

    // Latency: button high before edge 1, update lands at edge DC+3.
    @(negedge clk);
    rst = 0;
    inc = 1;
    apply(1, 0, 0);
    for (int k = 1; k <= DC + 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), {tens, ones}, (k < DC + 3) ? 8'h00 : 8'h01);
    end
    check("change_at_update", change, 1);
    @(posedge clk);
    #1;
    check("change_one_cycle", change, 0);
    repeat (12) @(negedge clk);
    inc = 0;
    repeat (12) @(negedge clk);
    check("no_auto_repeat", {tens, ones}, 8'h01);

    // Pulses shorter than DC are rejected.
    for (int n = 1; n < DC; n++) glitch(n);
    check("glitch_reject", {tens, ones}, 8'h01);

    // Carry and saturation.
    press(0, 0, 1, DC + 2, DC + 6);
    incs(9);
    check("count_09", {tens, ones}, 8'h09);
    incs(1);
    check("carry_10", {tens, ones}, 8'h10);
    incs(88);
    check("preload_98", {tens, ones}, 8'h98);
    incs(3);
    check("saturate_99", {tens, ones}, 8'h99);

    // Borrow and floor.
    press(0, 0, 1, DC + 2, DC + 6);
    incs(10);
    press(0, 1, 0, DC + 2, DC + 6);
    check("borrow_09", {tens, ones}, 8'h09);
    press(0, 0, 1, DC + 2, DC + 6);
    press(0, 1, 0, DC + 2, DC + 6);
    check("floor_00", {tens, ones}, 8'h00);
    press(0, 0, 1, DC + 2, DC + 6);
    check("clear_at_00", {tens, ones}, 8'h00);

    // Simultaneous presses.
    incs(42);
    press(1, 1, 0, DC + 2, DC + 6);
    check("inc_dec_same", {tens, ones}, 8'h42);
    press(1, 0, 1, DC + 2, DC + 6);
    check("inc_clr_same", {tens, ones}, 8'h00);

    // Async reset mid-cycle at 37, mid-debounce; held button counts once after.
    incs(37);
    check("preload_37", {tens, ones}, 8'h37);
    @(negedge clk);
    inc = 1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    model_score = 0;
    exp_q.delete();
    #1;
    check("async_reset_score", {tens, ones}, 8'h00);
    check("async_reset_change", change, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    apply(1, 0, 0);
    repeat (DC + 10) @(negedge clk);
    inc = 0;
    repeat (DC + 8) @(negedge clk);
    check("held_through_reset", {tens, ones}, 8'h01);

    // Randomized mix against the model.
    for (int k = 0; k < 120; k++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: press(1, 0, 0, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        3, 4:    press(0, 1, 0, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        5:       press(0, 0, 1, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        6:       press(1, 1, 0, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        7:       press(1, 0, 1, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        8:       press(1, 1, 1, $urandom_range(DC, DC + 6), $urandom_range(DC + 4, DC + 12));
        default: glitch($urandom_range(1, DC - 1));
      endcase
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_score", {tens, ones}, to_bcd(model_score));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Upstream stage of dual_7_seg in the scoreboard datapath.
- Takes three raw push-button inputs: increment, decrement and clear.
- Synchronizes, debounces and edge-detects each button, then maintains a two-digit BCD score in the range 00..99.
- Drives tens_o/ones_o directly into the seven-segment driver's tens_i/ones_i.

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive clk_i cycles a synchronized button level must differ from the debounced state before that state flips. Legal range >= 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- inc_btn_i  input  1  raw increment button, active-high, asynchronous to clk_i.
- dec_btn_i  input  1  raw decrement button, active-high, asynchronous to clk_i.
- clr_btn_i  input  1  raw clear button, active-high, asynchronous to clk_i.
- tens_o  output  4  BCD tens digit, 0..9.
- ones_o  output  4  BCD ones digit, 0..9.
- change_o  output  1  one-cycle pulse in the cycle after the score register changes value.

Behaviour:
- Reset: rst_i high asynchronously clears all registers.
  - Outputs: tens_o=0, ones_o=0, change_o=0.
  - Synchronizer flops, debounce counters and debounced states all go to 0.
  - Reset asserted mid-debounce discards any partial count.
  - After rst_i deasserts, a button still held high is treated as a new press; it goes through full debounce and counts once.
- Synchronizer: per button, two flops in series (s1, s2). s2 is the synchronized level.
- Debouncer (per button), evaluated each edge:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are rejected.
- Edge detect: press pulse = stable AND NOT stable_q, where stable_q is stable delayed one cycle. Only rising edges count; release produces no event.
- Latency: raw input high before edge 1 and held gives:
  - s2=1 after edge 2.
  - stable=1 after edge DEBOUNCE_CYCLES+2.
  - Score update at edge DEBOUNCE_CYCLES+3.
  - change_o high during the cycle after that edge.
- Score update, evaluated at each edge on the press pulses, in priority order:
  1. Clear pulse: score <= 00. Overrides inc/dec in the same cycle.
  2. Inc and dec pulses in the same cycle: no change.
  3. Inc pulse: add 1 in BCD. ones 9 -> 0 with tens+1. Saturate at 99 (99 + inc stays 99).
  4. Dec pulse: subtract 1 in BCD. ones 0 -> 9 with tens-1. Saturate at 00 (00 - dec stays 00).
- change_o:
  - Registered; high for exactly one cycle when the score register was written with a different value.
  - Not asserted on saturated or no-op events.
  - Not asserted on a clear at 00.
- Holding a button produces exactly one count; no auto-repeat.
- tens_o/ones_o never leave the 0..9 range. No illegal BCD codes are ever output.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset behaviour: assert rst_i asynchronously mid-cycle with score at 37 -> tens_o/ones_o go to 0/0 immediately without a clock edge; change_o=0.
- Single press latency: inc_btn_i high before edge 1, held 20 cycles -> score 00->01 exactly at edge 7, change_o high one cycle, no further counts while held.
- Glitch rejection: inc_btn_i pulses of 1, 2 and 3 cycles, separated by 10-cycle gaps -> score unchanged, change_o never asserts.
- Carry and saturation: 9 presses from 00 -> 09; 1 more -> 10. Preload to 98 via presses; 3 more presses -> 99, 99, 99, with change_o only on the 98->99 step.
- Borrow and floor: from 10, one dec press -> 09; from 00, a dec press -> 00 and change_o=0.
- Simultaneous events: inc and dec pressed in the same cycle at 42 -> stays 42. inc and clr pressed together at 42 -> 00 with one change_o pulse.
